serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu.sv | 189 ++++++++++++++++++
 tb/tb_serial_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU. Bitwise, ADD and NEG ops take one result bit
// per clock (LSB first, registered carry). Shift ops move a working register
// one position per clock. Results appear with a one-cycle done pulse.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_PASS = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_NEG  = 3'b111;

    localparam logic [SH_W:0] CNT_FULL = (SH_W+1)'(WIDTH);
    localparam logic [SH_W:0] CNT_ONE  = (SH_W+1)'(1);
    localparam logic [SH_W:0] CNT_ZERO = (SH_W+1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [SH_W:0]    cnt_r;
    logic             shift_en_r;

    logic             accept_s;
    logic             bit_s;
    logic             carry_nxt_s;
    logic             cout_s;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic [SH_W-1:0]  shamt_s;

    // Shift ops: true for SLL/SRL/SRA.
    function automatic logic is_shift(input logic [2:0] op_f);
        return (op_f == OP_SLL) || (op_f == OP_SRL) || (op_f == OP_SRA);
    endfunction

    // Number of RUN edges needed for an operation; a zero shift still takes one.
    function automatic logic [SH_W:0] step_count(input logic [2:0] op_f,
                                                 input logic [SH_W-1:0] sh_f);
        logic [SH_W:0] n;
        if (!is_shift(op_f)) begin
            n = CNT_FULL;
        end else if (sh_f == {SH_W{1'b0}}) begin
            n = CNT_ONE;
        end else begin
            n = {1'b0, sh_f};
        end
        return n;
    endfunction

    assign shamt_s  = b[SH_W-1:0];
    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // One serial step: next working registers and the would-be final result.
    always_comb begin
        bit_s       = 1'b0;
        carry_nxt_s = 1'b0;
        a_nxt_s     = {1'b0, a_r[WIDTH-1:1]};
        case (op_r)
            OP_AND:  bit_s = a_r[0] & b_r[0];
            OP_XOR:  bit_s = a_r[0] ^ b_r[0];
            OP_PASS: bit_s = a_r[0];
            OP_ADD: begin
                bit_s       = a_r[0] ^ b_r[0] ^ carry_r;
                carry_nxt_s = (a_r[0] & b_r[0]) | (a_r[0] & carry_r) | (b_r[0] & carry_r);
            end
            OP_NEG: begin
                bit_s       = ~b_r[0] ^ carry_r;
                carry_nxt_s = ~b_r[0] & carry_r;
            end
            OP_SLL: begin
                if (shift_en_r) a_nxt_s = {a_r[WIDTH-2:0], 1'b0};
                else            a_nxt_s = a_r;
            end
            OP_SRL: begin
                if (shift_en_r) a_nxt_s = {1'b0, a_r[WIDTH-1:1]};
                else            a_nxt_s = a_r;
            end
            OP_SRA: begin
                // The MSB never changes under SRA, so it is the original sign.
                if (shift_en_r) a_nxt_s = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
                else            a_nxt_s = a_r;
            end
            default: a_nxt_s = a_r;
        endcase
        acc_nxt_s = {bit_s, acc_r[WIDTH-1:1]};
        b_nxt_s   = {1'b0, b_r[WIDTH-1:1]};
        if (is_shift(op_r)) begin
            res_nxt_s = a_nxt_s;
            cout_s    = 1'b0;
        end else begin
            res_nxt_s = acc_nxt_s;
            cout_s    = carry_nxt_s;
        end
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= 3'b000;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
            shift_en_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= {WIDTH{1'b0}};
            carry      <= 1'b0;
            zero       <= 1'b1;
        end else if (accept_s) begin
            state_r    <= ST_RUN;
            op_r       <= op;
            a_r        <= a;
            b_r        <= b;
            acc_r      <= {WIDTH{1'b0}};
            carry_r    <= (op == OP_NEG);
            cnt_r      <= step_count(op, shamt_s);
            shift_en_r <= (shamt_s != {SH_W{1'b0}});
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                ST_RUN: begin
                    a_r     <= a_nxt_s;
                    b_r     <= b_nxt_s;
                    acc_r   <= acc_nxt_s;
                    carry_r <= carry_nxt_s;
                    cnt_r   <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= res_nxt_s;
                        carry   <= cout_s;
                        zero    <= (res_nxt_s == {WIDTH{1'b0}});
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: table-driven directed checks of serial_alu at WIDTH=8, plus
// hand-written sequences for ignored start, reset abort and back-to-back ops.
module tb_serial_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int n_checks;
    int n_fail;

    serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and count edges until done (bounded).
    task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, output int lat_o);
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        lat_o = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat_o++;
            if (done) break;
        end
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 40 edges");
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int t1;
        int t2;
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;

        vecs[0]  = '{3'b110, 8'hFF, 8'h01, 8'h00, 1'b1, 8};  // ADD wrap
        vecs[1]  = '{3'b101, 8'h90, 8'h03, 8'hF2, 1'b0, 3};  // SRA
        vecs[2]  = '{3'b111, 8'h00, 8'h05, 8'hFB, 1'b0, 8};  // NEG 5
        vecs[3]  = '{3'b111, 8'h00, 8'h00, 8'h00, 1'b1, 8};  // NEG 0
        vecs[4]  = '{3'b100, 8'h90, 8'h03, 8'h12, 1'b0, 3};  // SRL
        vecs[5]  = '{3'b011, 8'h81, 8'h00, 8'h81, 1'b0, 1};  // SLL by 0
        vecs[6]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 8};  // AND
        vecs[7]  = '{3'b001, 8'hA5, 8'h5A, 8'hFF, 1'b0, 8};  // XOR
        vecs[8]  = '{3'b010, 8'h7E, 8'hFF, 8'h7E, 1'b0, 8};  // PASS
        vecs[9]  = '{3'b110, 8'h12, 8'h34, 8'h46, 1'b0, 8};  // ADD
        vecs[10] = '{3'b111, 8'h00, 8'h80, 8'h80, 1'b0, 8};  // NEG min
        vecs[11] = '{3'b110, 8'h80, 8'h80, 8'h00, 1'b1, 8};  // ADD carry
        vecs[12] = '{3'b011, 8'h81, 8'hF9, 8'h02, 1'b0, 1};  // SLL, upper b ignored
        vecs[13] = '{3'b101, 8'h7F, 8'h07, 8'h00, 1'b0, 7};  // SRA to zero

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_carry",  {31'd0, carry}, 32'd0);
        check("rst_zero",   {31'd0, zero},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
            check($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].cy});
            check($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, (vecs[i].res == 8'h00)});
            @(posedge clk); #1;
            check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_result_held", i), {24'd0, result}, {24'd0, vecs[i].res});
        end

        // Start during RUN is ignored
        @(negedge clk);
        op = 3'b001; a = 8'hA5; b = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = 3'b000; a = 8'hFF; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        cyc = 3;
        t1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                pulses++;
                if (t1 < 0) t1 = cyc;
            end
        end
        check("ign_pulses", pulses, 1);
        check("ign_latency", t1, 8);
        check("ign_result", {24'd0, result}, 32'd0);
        check("ign_zero", {31'd0, zero}, 32'd1);

        // Reset aborts a running ADD
        @(negedge clk);
        op = 3'b110; a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(3'b110, 8'h12, 8'h34, lat);
        check("reissue_latency", lat, 8);
        check("reissue_result", {24'd0, result}, 32'h46);
        check("reissue_carry", {31'd0, carry}, 32'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        op = 3'b000; a = 8'hF0; b = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        op = 3'b010; a = 8'h7E; b = 8'h00;
        cyc = 0; t1 = -1; t2 = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (t1 >= 0 && cyc == t1 + 1) begin
                start = 1'b0;
                check("b2b_busy_second", {31'd0, busy}, 32'd1);
            end
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    check("b2b_result1", {24'd0, result}, 32'h30);
                end else begin
                    t2 = cyc;
                    check("b2b_result2", {24'd0, result}, 32'h7E);
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", t1, 8);
        check("b2b_spacing", t2 - t1, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
